// File: rtl/prescaler_pkg.sv
// prescaler_pkg: clock-select encodings and default taps shared by the prescaler.
package prescaler_pkg;
    localparam logic [2:0] CS_STOP     = 3'b000;
    localparam logic [2:0] CS_DIV1     = 3'b001;
    localparam logic [2:0] CS_DIV8     = 3'b010;
    localparam logic [2:0] CS_DIV64    = 3'b011;
    localparam logic [2:0] CS_DIV256   = 3'b100;
    localparam logic [2:0] CS_DIV1024  = 3'b101;
    localparam logic [2:0] CS_EXT_FALL = 3'b110;
    localparam logic [2:0] CS_EXT_RISE = 3'b111;

    localparam int DEF_TAP1        = 3;
    localparam int DEF_TAP2        = 6;
    localparam int DEF_TAP3        = 8;
    localparam int DEF_TAP4        = 10;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/ext_clk_sync.sv
// ext_clk_sync: synchronises one external timer pin and emits one-cycle edge pulses,
// gated off until the chain has been flushed after reset.
module ext_clk_sync
    import prescaler_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_MAX = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [PW-1:0]          r_prime;
    logic                   w_primed;
    logic                   w_pin;

    assign w_pin    = r_sync[SYNC_STAGES-1];
    assign w_primed = (r_prime == PRIME_MAX);
    assign o_rise   = w_primed & w_pin & ~r_prev;
    assign o_fall   = w_primed & ~w_pin & r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_prime <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev  <= w_pin;
            r_prime <= w_primed ? r_prime : r_prime + 1'b1;
        end
    end
endmodule

// File: rtl/prescaler_mc.sv
// prescaler_mc: one shared prescale counter feeding NUM_CH clock-enables, each with
// its own clock select, plus external-pin clocking, prescaler reset and sync hold.
module prescaler_mc
    import prescaler_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int TAP1        = DEF_TAP1,
    parameter int TAP2        = DEF_TAP2,
    parameter int TAP3        = DEF_TAP3,
    parameter int TAP4        = DEF_TAP4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [3*NUM_CH-1:0] cs,
    input  logic [NUM_CH-1:0]   t_pin,
    input  logic                psr,
    input  logic                tsm,
    output logic [NUM_CH-1:0]   clk_en,
    output logic                psr_busy
);
    logic [TAP4-1:0] r_cnt;
    logic            r_hold;
    logic [3:0]      w_div;

    assign psr_busy = r_hold | psr;
    // terminal counts for /8, /64, /256, /1024, silenced while the prescaler is held
    assign w_div = {&r_cnt[TAP4-1:0], &r_cnt[TAP3-1:0], &r_cnt[TAP2-1:0], &r_cnt[TAP1-1:0]}
                 & {4{~psr_busy}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_hold <= 1'b0;
        end else begin
            r_cnt  <= psr_busy ? '0 : r_cnt + 1'b1;
            r_hold <= tsm & (r_hold | psr);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [2:0] w_cs;
        logic       w_rise;
        logic       w_fall;

        assign w_cs = cs[3*g +: 3];

        ext_clk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_pin  (t_pin[g]),
            .o_rise (w_rise),
            .o_fall (w_fall)
        );

        assign clk_en[g] = (w_cs == CS_DIV1)
                         | ((w_cs == CS_DIV8)     & w_div[0])
                         | ((w_cs == CS_DIV64)    & w_div[1])
                         | ((w_cs == CS_DIV256)   & w_div[2])
                         | ((w_cs == CS_DIV1024)  & w_div[3])
                         | ((w_cs == CS_EXT_FALL) & w_fall)
                         | ((w_cs == CS_EXT_RISE) & w_rise);
    end
endmodule
